mackerel_bus_ctrl: RTL and testbench

Parametrised successor to the board's glue decoder: it decodes the 68000 address/function-code bus into ROM, RAM-bank and peripheral selects, and owns the boot-time ROM overlay. It generates DTACK with per-region wait states, plus per-level interrupt acknowledge and autovector (VPA). An optional bus-error watchdog can be compiled in. It sits between the CPU and every memory/peripheral chip select on the mainboard CPLD.

---
 rtl/mackerel_bus_pkg.sv | 27 ++
 rtl/mackerel_wait_timer.sv | 41 ++++
 rtl/mackerel_bus_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_mackerel_bus_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mackerel_bus_pkg.sv
// mackerel_bus_pkg: shared types and constants for the 68000 bus controller.
//   region_e      : decoded target of the current bus cycle
//   ROM_BASE      : A21:A15 of the boot ROM window (0x3F8000)
//   EXT_BASE      : A21:A15 of peripheral slot 0 (0x3F0000); slot k sits k windows below
//   FC_CPU_SPACE  : function code of a CPU-space cycle
//   IACK_CODE     : A19:A16 pattern of an interrupt-acknowledge cycle
package mackerel_bus_pkg;

   typedef enum logic [2:0] {
      RGN_NONE,
      RGN_ROM,
      RGN_RAM,
      RGN_EXT,
      RGN_IACK
   } region_e;

   localparam logic [6:0] ROM_BASE     = 7'h7F;
   localparam logic [6:0] EXT_BASE     = 7'h7E;
   localparam logic [2:0] FC_CPU_SPACE = 3'b111;
   localparam logic [3:0] IACK_CODE    = 4'hF;

   // A21:A15 of peripheral slot k (each slot is one 32KB window below the last)
   function automatic logic [6:0] ext_base(input int unsigned k);
      return EXT_BASE - k[6:0];
   endfunction

endpackage

// File: rtl/mackerel_wait_timer.sv
// mackerel_wait_timer: loadable down-counter with a zero flag.
//   clk, rst  : clock, asynchronous active-high reset (count clears to 0)
//   load      : load load_val this cycle (wins over en)
//   en        : decrement by one, holding at zero
//   load_val  : value to load
//   zero      : count is zero
module mackerel_wait_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/mackerel_bus_ctrl.sv
// mackerel_bus_ctrl: 68000 glue decoder. Decodes A21:A15/FC into ROM, RAM-bank
// and peripheral selects, owns the boot-time ROM overlay, and generates DTACK
// (per-region wait states), per-level IACK and autovector VPA.
// Optional build macro MACKEREL_BERR_EN adds a bus-error watchdog on BERR;
// without it BERR is tied high.
// Ports:
//   CLK, RST   : CPU clock, asynchronous active-high reset
//   ADDR       : A23:A1 (A23:A22 ignored, mirrored)
//   FC, AS     : function code, address strobe (active-low)
//   DTACK_EXT  : per-slot peripheral DTACK (active-low)
//   CLK_SLOW   : CLK / CLK_DIV, 50% duty
//   BOOT       : high once the ROM overlay has ended
//   ROMEN, RAMEN, EXTEN : active-low chip selects
//   DTACK, VPA, BERR    : active-low CPU handshakes
//   IACK       : per-level interrupt acknowledge, active-low one-hot
module mackerel_bus_ctrl
   import mackerel_bus_pkg::*;
#(
   parameter int         NUM_RAM      = 4,
   parameter int         NUM_EXT      = 3,
   parameter int         RAM_WAIT     = 0,
   parameter int         ROM_WAIT     = 1,
   parameter int         BOOT_CYCLES  = 8,
   parameter int         CLK_DIV      = 2,
   parameter int         BERR_CYCLES  = 64,
   parameter logic [6:0] AUTOVEC_MASK = 7'b1011111
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [23:1]        ADDR,
   input  logic [2:0]         FC,
   input  logic               AS,
   input  logic [NUM_EXT-1:0] DTACK_EXT,
   output logic               CLK_SLOW,
   output logic               BOOT,
   output logic               ROMEN,
   output logic [NUM_RAM-1:0] RAMEN,
   output logic [NUM_EXT-1:0] EXTEN,
   output logic               DTACK,
   output logic               VPA,
   output logic               BERR,
   output logic [6:0]         IACK
);

   localparam int BOOT_W   = $clog2(BOOT_CYCLES + 1);
   localparam int WAIT_W   = 8;
   localparam int HALF_DIV = CLK_DIV / 2;

   logic              as_q, as_d;
   logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
   logic [3:0]        div_cnt_q, div_cnt_d;
   logic              clk_slow_q, clk_slow_d;

   region_e           region;
   logic [1:0]        ram_idx;
   logic [2:0]        lvl;
   logic [7:0]        av_vec;
   logic              autovec;
   logic              mem_cyc, cpu_cyc;
   logic              cyc_start, cyc_active, as_rise;
   logic [WAIT_W-1:0] wait_load;
   logic              wait_zero;
   logic              dtack_n;
   logic              unused_addr;

   // Address bits outside the decode window (A23:A22 mirror, A14:A4 offset)
   assign unused_addr = ^{ADDR[23:22], ADDR[14:4]};

   // Cycle tracking from the registered AS: start = first low sample,
   // active = low sampled and still low, rise = completion of a cycle.
   assign cyc_start  = ~AS &  as_q;
   assign cyc_active = ~AS & ~as_q;
   assign as_rise    =  AS & ~as_q;
   assign mem_cyc    = ~AS & (FC != FC_CPU_SPACE);
   assign cpu_cyc    = ~AS & (FC == FC_CPU_SPACE);

   assign BOOT     = (boot_cnt_q == BOOT_W'(BOOT_CYCLES));
   assign CLK_SLOW = clk_slow_q;

   assign lvl     = ADDR[3:1];
   assign av_vec  = {AUTOVEC_MASK, 1'b0};
   assign autovec = av_vec[lvl];

   always_comb begin
      as_d       = AS;
      boot_cnt_d = boot_cnt_q;
      if (as_rise && !BOOT) begin
         boot_cnt_d = boot_cnt_q + 1'b1;
      end
      div_cnt_d  = div_cnt_q + 4'd1;
      clk_slow_d = clk_slow_q;
      if (div_cnt_q == 4'(HALF_DIV - 1)) begin
         div_cnt_d  = '0;
         clk_slow_d = ~clk_slow_q;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         as_q       <= 1'b1;
         boot_cnt_q <= '0;
         div_cnt_q  <= '0;
         clk_slow_q <= 1'b0;
      end else begin
         as_q       <= as_d;
         boot_cnt_q <= boot_cnt_d;
         div_cnt_q  <= div_cnt_d;
         clk_slow_q <= clk_slow_d;
      end
   end

   // Region decode. During the overlay every memory cycle goes to ROM.
   always_comb begin
      region  = RGN_NONE;
      ram_idx = '0;
      if (FC == FC_CPU_SPACE) begin
         if ((ADDR[19:16] == IACK_CODE) && (lvl != 3'd0)) begin
            region = RGN_IACK;
         end
      end else if (!BOOT) begin
         region = RGN_ROM;
      end else if (ADDR[21:15] == ROM_BASE) begin
         region = RGN_ROM;
      end else begin
         // Each RAM bank spans 16 windows, so A21:A19 is the bank number
         if (32'(ADDR[21:19]) < NUM_RAM) begin
            region  = RGN_RAM;
            ram_idx = ADDR[20:19];
         end
         for (int k = 0; k < NUM_EXT; k++) begin
            if (ADDR[21:15] == ext_base(k)) begin
               region = RGN_EXT;
            end
         end
      end
   end

   always_comb begin
      ROMEN = ~(mem_cyc & (region == RGN_ROM));
      RAMEN = '1;
      for (int b = 0; b < NUM_RAM; b++) begin
         RAMEN[b] = ~(mem_cyc & (region == RGN_RAM) & (ram_idx == 2'(b)));
      end
      EXTEN = '1;
      for (int k = 0; k < NUM_EXT; k++) begin
         EXTEN[k] = ~(mem_cyc & (region == RGN_EXT) & (ADDR[21:15] == ext_base(k)));
      end
      IACK = '1;
      for (int i = 0; i < 7; i++) begin
         IACK[i] = ~(cpu_cyc & (region == RGN_IACK) & (lvl == 3'(i + 1)));
      end
   end

   assign wait_load = (region == RGN_ROM) ? WAIT_W'(ROM_WAIT) : WAIT_W'(RAM_WAIT);

   mackerel_wait_timer #(.WIDTH(WAIT_W)) u_wait (
      .clk      (CLK),
      .rst      (RST),
      .load     (cyc_start),
      .en       (cyc_active),
      .load_val (wait_load),
      .zero     (wait_zero)
   );

   always_comb begin
      dtack_n = 1'b1;
      case (region)
         RGN_ROM, RGN_RAM: dtack_n = ~(cyc_active & wait_zero);
         // Only one EXTEN can be low, so the matching slot's DTACK passes through
         RGN_EXT:          dtack_n = &(EXTEN | DTACK_EXT);
         // Non-autovectored levels take their vector from the MFP on slot 0
         RGN_IACK:         dtack_n = autovec | AS | DTACK_EXT[0];
         default:          dtack_n = 1'b1;
      endcase
   end

   // RST drops any acknowledge at once, including the combinational MFP path
   assign DTACK = dtack_n | RST;
   assign VPA   = ~((region == RGN_IACK) & autovec & cyc_active);

`ifdef MACKEREL_BERR_EN
   localparam int WD_W = $clog2(BERR_CYCLES + 1);

   logic wd_zero;
   logic acked_q, acked_d;

   // Once the watchdog expires the acknowledge flag freezes, so BERR holds until AS negates
   always_comb begin
      acked_d = acked_q;
      if (cyc_start) begin
         acked_d = 1'b0;
      end else if (cyc_active && !wd_zero && (!DTACK || !VPA)) begin
         acked_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acked_q <= 1'b0;
      end else begin
         acked_q <= acked_d;
      end
   end

   mackerel_wait_timer #(.WIDTH(WD_W)) u_watchdog (
      .clk      (CLK),
      .rst      (RST),
      .load     (cyc_start),
      .en       (cyc_active & ~acked_q),
      .load_val (WD_W'(BERR_CYCLES)),
      .zero     (wd_zero)
   );

   assign BERR = ~(cyc_active & wd_zero & ~acked_q);
`else
   localparam int unused_berr_cycles = BERR_CYCLES;

   assign BERR = 1'b1;
`endif

endmodule

// File: tb/tb_mackerel_bus_ctrl.sv
// tb_mackerel_bus_ctrl: directed bench for mackerel_bus_ctrl with an
// address-range / edge-count model compared against the DUT every cycle.
module tb_mackerel_bus_ctrl;

   localparam int         NUM_RAM     = 4;
   localparam int         NUM_EXT     = 3;
   localparam int         RAM_WAIT    = 0;
   localparam int         ROM_WAIT    = 1;
   localparam int         BOOT_CYCLES = 8;
   localparam int         CLK_DIV     = 2;
   localparam int         BERR_CYCLES = 64;
   localparam logic [6:0] AV_MASK     = 7'b1011111;

   logic               clk = 1'b0;
   logic               rst;
   logic [23:0]        byte_a;
   logic [23:1]        addr;
   logic [2:0]         fc;
   logic               as_n;
   logic [NUM_EXT-1:0] dtack_ext;
   logic               clk_slow, boot, romen, dtack, vpa, berr;
   logic [NUM_RAM-1:0] ramen;
   logic [NUM_EXT-1:0] exten;
   logic [6:0]         iack;

   assign addr = byte_a[23:1];

   always #5 clk = ~clk;

   mackerel_bus_ctrl #(
      .NUM_RAM(NUM_RAM), .NUM_EXT(NUM_EXT), .RAM_WAIT(RAM_WAIT), .ROM_WAIT(ROM_WAIT),
      .BOOT_CYCLES(BOOT_CYCLES), .CLK_DIV(CLK_DIV), .BERR_CYCLES(BERR_CYCLES),
      .AUTOVEC_MASK(AV_MASK)
   ) dut (
      .CLK(clk), .RST(rst), .ADDR(addr), .FC(fc), .AS(as_n), .DTACK_EXT(dtack_ext),
      .CLK_SLOW(clk_slow), .BOOT(boot), .ROMEN(romen), .RAMEN(ramen), .EXTEN(exten),
      .DTACK(dtack), .VPA(vpa), .BERR(berr), .IACK(iack)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: CLK edges since reset, AS-low edges in the current cycle,
   // completed bus cycles since reset.
   int n_clk   = 0;
   int n_edges = 0;
   int m_done  = 0;
`ifdef MACKEREL_BERR_EN
   bit m_acked = 1'b0;
`endif

   always @(posedge clk) begin
      if (rst) begin
         n_clk   = 0;
         n_edges = 0;
         m_done  = 0;
      end else begin
         n_clk++;
         if (as_n) begin
            if (n_edges > 0) m_done++;
            n_edges = 0;
`ifdef MACKEREL_BERR_EN
            m_acked = 1'b0;
`endif
         end else begin
            n_edges++;
         end
      end
   end

   function automatic void model(output logic romen_e, output logic [NUM_RAM-1:0] ramen_e,
                                 output logic [NUM_EXT-1:0] exten_e, output logic dtack_e,
                                 output logic vpa_e, output logic [6:0] iack_e);
      int off;
      int lvl;
      romen_e = 1'b1; ramen_e = '1; exten_e = '1; dtack_e = 1'b1; vpa_e = 1'b1; iack_e = '1;
      if (as_n) return;
      off = int'(byte_a[21:0]);
      if (fc == 3'b111) begin
         lvl = int'(byte_a[3:1]);
         if (byte_a[19:16] == 4'hF && lvl != 0) begin
            iack_e[lvl-1] = 1'b0;
            if (AV_MASK[lvl-1]) vpa_e = (n_edges == 0);
            else dtack_e = dtack_ext[0];
         end
      end else if (m_done < BOOT_CYCLES || off >= 'h3F8000) begin
         romen_e = 1'b0;
         dtack_e = (n_edges < ROM_WAIT + 1);
      end else if (off < NUM_RAM * 'h80000) begin
         ramen_e[off / 'h80000] = 1'b0;
         dtack_e = (n_edges < RAM_WAIT + 1);
      end else begin
         for (int k = 0; k < NUM_EXT; k++) begin
            if (off >= 'h3F0000 - k * 'h8000 && off < 'h3F8000 - k * 'h8000) begin
               exten_e[k] = 1'b0;
               dtack_e    = dtack_ext[k];
            end
         end
      end
   endfunction

   always @(negedge clk) begin
      logic r_e, d_e, v_e, b_e;
      logic [NUM_RAM-1:0] ra_e;
      logic [NUM_EXT-1:0] ex_e;
      logic [6:0] ia_e;
      if (!rst) begin
         model(r_e, ra_e, ex_e, d_e, v_e, ia_e);
`ifdef MACKEREL_BERR_EN
         b_e = !(!as_n && n_edges >= BERR_CYCLES + 1 && !m_acked);
         if (!as_n && (!d_e || !v_e) && n_edges <= BERR_CYCLES) m_acked = 1'b1;
`else
         b_e = 1'b1;
`endif
         check("m_romen", romen, r_e);
         check("m_ramen", ramen, ra_e);
         check("m_exten", exten, ex_e);
         check("m_dtack", dtack, d_e);
         check("m_vpa", vpa, v_e);
         check("m_iack", iack, ia_e);
         check("m_berr", berr, b_e);
         check("m_boot", boot, m_done >= BOOT_CYCLES);
         check("m_clk_slow", clk_slow, (n_clk / (CLK_DIV / 2)) % 2);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic bus(input logic [23:0] a, input logic [2:0] f, input int n_low);
      byte_a = a; fc = f; as_n = 1'b0;
      tick(n_low);
      as_n = 1'b1;
      tick(1);
   endtask

   logic [23:0] map_vec [12] = '{24'h000000, 24'h080000, 24'h100000, 24'h1FFFFE,
                                 24'h3F8000, 24'h3FFFFE, 24'h3F0000, 24'h3E8000,
                                 24'h3E0000, 24'h3D8000, 24'h200000, 24'hC80000};

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; as_n = 1'b1; fc = 3'b101; byte_a = '0; dtack_ext = '1;
      #1;
      check("rst_boot", boot, 1'b0);
      check("rst_clk_slow", clk_slow, 1'b0);
      check("rst_dtack", dtack, 1'b1);
      check("rst_vpa", vpa, 1'b1);
      check("rst_berr", berr, 1'b1);
      check("rst_iack", iack, 7'h7F);
      check("rst_selects", {romen, ramen, exten}, 8'hFF);
      as_n = 1'b0;
      #1;
      check("rst_romen_as", romen, 1'b0);
      check("rst_ramen_as", ramen, 4'hF);
      check("rst_dtack_as", dtack, 1'b1);
      as_n = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);

      // Boot overlay: eight cycles at 0x000000 all go to ROM
      for (int i = 0; i < BOOT_CYCLES; i++) begin
         byte_a = 24'h000000; fc = 3'b101; as_n = 1'b0;
         #1;
         check("boot_romen", romen, 1'b0);
         check("boot_ramen0", ramen[0], 1'b1);
         tick(2);
         check("boot_still_0", boot, 1'b0);
         as_n = 1'b1;
         tick(1);
      end
      #1;
      check("boot_set", boot, 1'b1);
      as_n = 1'b0;
      #1;
      check("ninth_ramen", ramen, 4'b1110);
      check("ninth_romen", romen, 1'b1);
      tick(1);
      check("ninth_dtack", dtack, 1'b0);
      as_n = 1'b1;
      tick(1);

      // ROM wait state: DTACK on the 2nd edge after AS low
      byte_a = 24'h3F8000; as_n = 1'b0;
      tick(1);
      check("rom_dtack_e1", dtack, 1'b1);
      tick(1);
      check("rom_dtack_e2", dtack, 1'b0);
      as_n = 1'b1;
      #1;
      check("rom_dtack_release", dtack, 1'b1);
      tick(1);

      // RAM bank 1, no wait
      byte_a = 24'h080000; as_n = 1'b0;
      #1;
      check("ram1_select", ramen, 4'b1101);
      check("ram1_dtack_pre", dtack, 1'b1);
      tick(1);
      check("ram1_dtack_e1", dtack, 1'b0);
      as_n = 1'b1;
      tick(1);

      // Peripheral slot 1, external DTACK from cycle 5
      byte_a = 24'h3E8000; as_n = 1'b0;
      #1;
      check("ext1_select", exten, 3'b101);
      tick(4);
      check("ext1_dtack_wait", dtack, 1'b1);
      dtack_ext[1] = 1'b0;
      #1;
      check("ext1_dtack_low", dtack, 1'b0);
      tick(2);
      check("ext1_dtack_hold", dtack, 1'b0);
      as_n = 1'b1;
      #1;
      check("ext1_release", dtack, 1'b1);
      dtack_ext = '1;
      tick(1);

      // Interrupt acknowledge, level 2 autovectored
      byte_a = 24'hFFFFF4; fc = 3'b111; as_n = 1'b0;
      #1;
      check("iack2_lines", iack, 7'b1111101);
      check("iack2_vpa_pre", vpa, 1'b1);
      tick(1);
      check("iack2_vpa", vpa, 1'b0);
      check("iack2_dtack", dtack, 1'b1);
      as_n = 1'b1;
      #1;
      check("iack2_vpa_release", vpa, 1'b1);
      tick(1);

      // Level 6: vectored by the MFP via DTACK_EXT[0]
      byte_a = 24'hFFFFFC; as_n = 1'b0;
      #1;
      check("iack6_lines", iack, 7'b1011111);
      tick(2);
      check("iack6_dtack_wait", dtack, 1'b1);
      check("iack6_vpa", vpa, 1'b1);
      dtack_ext[0] = 1'b0;
      #1;
      check("iack6_dtack", dtack, 1'b0);
      as_n = 1'b1;
      dtack_ext = '1;
      tick(1);

      // Level 0 is ignored
      byte_a = 24'hFFFFF0; as_n = 1'b0;
      tick(2);
      check("iack0_lines", iack, 7'h7F);
      check("iack0_ack", {dtack, vpa}, 2'b11);
      as_n = 1'b1;
      tick(1);

      // Memory map sweep with peripherals acknowledging immediately
      dtack_ext = '0;
      foreach (map_vec[i]) bus(map_vec[i], 3'b101, 3);
      for (int l = 0; l < 8; l++) bus(24'hFFFFF0 | 24'(l << 1), 3'b111, 3);
      bus(24'hF00000, 3'b111, 3);
      dtack_ext = '1;

      // Unmapped access held long
      byte_a = 24'h200000; fc = 3'b101; as_n = 1'b0;
      #1;
      check("unmapped_selects", {romen, ramen, exten}, 8'hFF);
`ifdef MACKEREL_BERR_EN
      tick(BERR_CYCLES);
      check("berr_before", berr, 1'b1);
      tick(1);
      check("berr_fire", berr, 1'b0);
      tick(3);
      check("berr_hold", berr, 1'b0);
      as_n = 1'b1;
      #1;
      check("berr_release", berr, 1'b1);
`else
      tick(BERR_CYCLES + 6);
      check("berr_tied", berr, 1'b1);
      check("unmapped_dtack", dtack, 1'b1);
      as_n = 1'b1;
`endif
      tick(1);

      // Reset in the middle of an acknowledged RAM cycle
      byte_a = 24'h000000; as_n = 1'b0;
      tick(2);
      check("mid_dtack_pre", dtack, 1'b0);
      rst = 1'b1;
      #1;
      check("mid_dtack_drop", dtack, 1'b1);
      check("mid_boot_clear", boot, 1'b0);
      check("mid_ramen", ramen, 4'hF);
      check("mid_romen", romen, 1'b0);
      tick(1);
      rst = 1'b0;
      tick(1);
      check("mid_clk_slow_1", clk_slow, 1'b1);
      check("mid_rom_dtack_e1", dtack, 1'b1);
      tick(1);
      check("mid_clk_slow_2", clk_slow, 1'b0);
      check("mid_rom_dtack_e2", dtack, 1'b0);
      as_n = 1'b1;
      tick(2);
      check("mid_boot_restart", boot, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
